// File: rtl/clk_period_meter.sv
// Measures rising-to-rising period and high time of a slow clock-like input, in clk cycles.
// Latency: meas_valid one cycle after the sampled rise (+2 with CLK_PERIOD_METER_SYNC_EN).
// Backpressure: none; results are overwritten on every completed period.
module clk_period_meter #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             syn_n_rst,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             meas_valid,
    output logic             timeout
);
    localparam logic [WIDTH-1:0] TIMEOUT_CNT = WIDTH'(TIMEOUT);
    localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);

    typedef enum logic [1:0] {
        WAIT_FIRST,
        MEASURE,
        TIMED_OUT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] hcnt;
    logic             sig_s;
    logic             sig_d;
    logic             rise;

`ifdef CLK_PERIOD_METER_SYNC_EN
    logic sync_q1;
    logic sync_q2;

    always_ff @(posedge clk) begin
        if (!syn_n_rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= sig_in;
            sync_q2 <= sync_q1;
        end
    end

    assign sig_s = sync_q2;
`else
    assign sig_s = sig_in;
`endif

    // sig_d clears in reset, so an input already high at release reads as a rise.
    always_ff @(posedge clk) begin
        if (!syn_n_rst) begin
            sig_d <= 1'b0;
        end else begin
            sig_d <= sig_s;
        end
    end

    assign rise = sig_s & ~sig_d;

    always_ff @(posedge clk) begin
        if (!syn_n_rst) begin
            state      <= WAIT_FIRST;
            cnt        <= '0;
            hcnt       <= '0;
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            case (state)
                WAIT_FIRST: begin
                    if (rise) begin
                        cnt   <= ONE;
                        hcnt  <= ONE;
                        state <= MEASURE;
                    end
                end
                MEASURE: begin
                    // A rise landing exactly on cnt==TIMEOUT is still a valid period.
                    if (rise) begin
                        period     <= cnt;
                        high_time  <= hcnt;
                        meas_valid <= 1'b1;
                        cnt        <= ONE;
                        hcnt       <= ONE;
                    end else if (cnt == TIMEOUT_CNT) begin
                        timeout <= 1'b1;
                        state   <= TIMED_OUT;
                    end else begin
                        cnt <= cnt + ONE;
                        if (sig_s) begin
                            hcnt <= hcnt + ONE;
                        end
                    end
                end
                TIMED_OUT: begin
                    if (rise) begin
                        timeout <= 1'b0;
                        cnt     <= ONE;
                        hcnt    <= ONE;
                        state   <= MEASURE;
                    end
                end
                default: begin
                    state <= WAIT_FIRST;
                end
            endcase
        end
    end

endmodule

// File: doc/clk_period_meter.md
CLK_PERIOD_METER -- requirements
Module: clk_period_meter

Interface
REQ-001 SHALL have parameter WIDTH, default 16, which sets the width of the period and high-time counters and outputs.
REQ-002 SHALL have parameter TIMEOUT, default 1000, which is the number of clk cycles without a rising edge before timeout is declared; legal range 2 <= TIMEOUT <= 2^WIDTH-1.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port syn_n_rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port sig_in, input, 1 bit: the slow clock-like signal under measurement, e.g. the output of a clock divider.
REQ-006 SHALL have port period, output, WIDTH bits: the last measured rising-to-rising period, in clk cycles.
REQ-007 SHALL have port high_time, output, WIDTH bits: the last measured high phase, in clk cycles.
REQ-008 SHALL have port meas_valid, output, 1 bit: a one-cycle pulse when period and high_time update.
REQ-009 SHALL have port timeout, output, 1 bit: level, high while no rising edge has been seen for TIMEOUT cycles.

Function
REQ-010 SHALL sample sig_in into sig_s, and SHALL register sig_s into sig_d each cycle.
REQ-011 SHALL detect a rising edge as rise = sig_s & ~sig_d.
REQ-012 SHALL implement the FSM states WAIT_FIRST, MEASURE and TIMED_OUT.
REQ-013 In WAIT_FIRST, on rise, the FSM SHALL load cnt=1 and hcnt=1 and go to MEASURE; it SHALL NOT assert meas_valid.
REQ-014 In MEASURE, when rise is absent, the FSM SHALL increment cnt by 1 and increment hcnt by 1 only when sig_s=1.
REQ-015 In MEASURE, on rise, the FSM SHALL register period<=cnt and high_time<=hcnt, assert meas_valid for exactly the next cycle, and reload cnt=1 and hcnt=1.
REQ-016 In MEASURE, when cnt==TIMEOUT and rise is absent, the FSM SHALL set timeout=1, go to TIMED_OUT, and leave period and high_time unchanged.
REQ-017 When rise and cnt==TIMEOUT occur in the same cycle, the rise SHALL take priority: the measurement is taken (period=TIMEOUT) and timeout stays 0.
REQ-018 In TIMED_OUT, the counters SHALL hold; on rise, the FSM SHALL clear timeout, load cnt=1 and hcnt=1, go to MEASURE, and SHALL NOT assert meas_valid.
REQ-019 Counters SHALL never wrap; TIMEOUT bounds cnt, and hcnt <= cnt.
REQ-020 Latency: meas_valid SHALL be high in the cycle after the clk edge at which rise is sampled (0 extra cycles without the synchronizer).
REQ-021 A constant-high or constant-low sig_in SHALL produce no rise, which leads to timeout after the first edge.

Reset
REQ-022 While syn_n_rst=0 at a clk edge, the block SHALL set state=WAIT_FIRST, cnt=0, hcnt=0, sig_d=0, period=0, high_time=0, meas_valid=0 and timeout=0.
REQ-023 Reset SHALL be synchronous only: asserting syn_n_rst between clk edges SHALL have no effect until the next edge.
REQ-024 Reset mid-measurement SHALL discard the partial count; the first rise after release SHALL only arm the FSM (WAIT_FIRST) and SHALL produce no meas_valid.
REQ-025 If sig_in=1 at reset release, that SHALL count as a rise, because sig_d resets to 0.

Configuration
REQ-026 SHALL support the macro CLK_PERIOD_METER_SYNC_EN.
REQ-027 When CLK_PERIOD_METER_SYNC_EN is defined, sig_s SHALL be the output of a 2-flop synchronizer on sig_in, reset to 0, which adds 2 cycles to REQ-020 latency; measured values SHALL be unchanged for a steady input.
REQ-028 When CLK_PERIOD_METER_SYNC_EN is undefined, sig_s SHALL equal sig_in directly, and sig_in is then required to be synchronous to clk.

Verification
REQ-029 The bench SHALL apply a 10 ns clk, hold syn_n_rst low for 2 cycles, then apply sig_in = clk/2 (toggling each cycle) -> from the second rise on: period=2, high_time=1, meas_valid every 2 cycles, timeout=0.
REQ-030 The bench SHALL apply sig_in with high 3 cycles and low 5 cycles, repeating -> period=8, high_time=3, one meas_valid pulse per 8 cycles.
REQ-031 The bench SHALL use TIMEOUT=64, give one rise, then hold sig_in low -> timeout=1 exactly 64 cycles after the rise cycle, with period/high_time holding their prior values; the next rise -> timeout=0 and no meas_valid; the following rise -> a valid measurement.
REQ-032 The bench SHALL assert syn_n_rst=0 in the middle of a period-8 stream -> all outputs 0 next edge; after release, the first rise gives no meas_valid and the second rise gives period=8.
REQ-033 The bench SHALL use TIMEOUT=8 with a period-8 input -> rise at cnt==8 gives period=8, meas_valid=1, and timeout never asserts.
REQ-034 The bench SHALL repeat REQ-029 with CLK_PERIOD_METER_SYNC_EN defined -> the same values, with meas_valid delayed by 2 cycles relative to the undefined build.
